// File: rtl/fp_pkg.sv
// Shared FP32 constants and pipeline bundles for the multiplier datapath.
package fp_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 24;
    localparam int PROD_W  = 48;
    localparam int EXP_W   = 10;

    typedef struct packed {
        logic                    valid;
        logic [MANT_W-1:0]       m;
        logic                    g;
        logic                    s;
        logic signed [EXP_W-1:0] e;
        logic                    uf;
        logic                    sign;
        logic                    zero;
        logic                    invalid;
    } nrm_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [MANT_W-1:0] m;
        logic [7:0]        e;
        logic              zero;
        logic              ovf;
        logic              uf;
        logic              invalid;
        logic              inexact;
    } res_t;

endpackage

// File: rtl/rne_rounder.sv
// Combinational round-to-nearest-even with carry, overflow and subnormal fixup.
module rne_rounder
    import fp_pkg::*;
(
    input  logic                    m_i_dummy_unused_guard,
    input  logic [MANT_W-1:0]       m_i,
    input  logic                    g_i,
    input  logic                    s_i,
    input  logic signed [EXP_W-1:0] e_i,
    input  logic                    uf_i,
    input  logic                    zero_i,
    input  logic                    invalid_i,
    output logic [MANT_W-1:0]       m_o,
    output logic [7:0]              e_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic                    inexact_o
);

    logic                    rnd;
    logic [MANT_W:0]         r;
    logic signed [EXP_W-1:0] e_r;
    logic                    unused;

    assign unused = m_i_dummy_unused_guard;

    always_comb begin
        rnd         = g_i & (s_i | m_i[0]);
        r           = {1'b0, m_i} + {{MANT_W{1'b0}}, rnd};
        e_r         = e_i + {{(EXP_W-1){1'b0}}, r[MANT_W]};
        m_o         = r[MANT_W] ? 24'h800000 : r[MANT_W-1:0];
        e_o         = e_r[7:0];
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        inexact_o   = g_i | s_i;
        // A subnormal that rounds up to the hidden bit becomes the smallest normal.
        if (uf_i) begin
            e_o         = r[MANT_W-1] ? 8'd1 : 8'd0;
            underflow_o = ~r[MANT_W-1];
        end else if (e_r >= 10'sd255) begin
            overflow_o = 1'b1;
            m_o        = '0;
            e_o        = 8'hFF;
        end
        if (invalid_i | zero_i) begin
            m_o         = '0;
            e_o         = '0;
            overflow_o  = 1'b0;
            underflow_o = 1'b0;
            inexact_o   = 1'b0;
        end
    end

endmodule

// File: rtl/round_normalize.sv
// Two-stage FP32 multiplier normalize (stage 1) and RNE round (stage 2).
module round_normalize
    import fp_pkg::*;
#(
    parameter int LAT       = 2,
    parameter int MAX_SHIFT = 25
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] prod,
    input  logic [EXP_W-1:0]  exp_sum,
    input  logic              sign_in,
    input  logic              zero_in,
    input  logic              invalid_in,
    output logic              out_valid,
    output logic              Sz_out,
    output logic [MANT_W-1:0] M_out,
    output logic [7:0]        E_out,
    output logic              initial_zero_flag,
    output logic              overflow_flag,
    output logic              underflow_case,
    output logic              invalid_flag,
    output logic              inexact_flag
);

    if (LAT != 2) begin : g_lat_chk
        $error("round_normalize supports LAT=2 only");
    end

    nrm_t nrm_d, nrm_q;
    res_t res_d, res_q;

    logic [MANT_W:0]         mg_n;
    logic                    s_n;
    logic signed [EXP_W-1:0] e_n;
    logic [EXP_W:0]          sh_raw;
    logic [4:0]              sh;
    logic [2*MANT_W+1:0]     ext;

    always_comb begin
        if (prod[47]) begin
            mg_n = prod[47:23];
            s_n  = |prod[22:0];
            e_n  = exp_sum + 10'd1;
        end else begin
            mg_n = prod[46:22];
            s_n  = |prod[21:0];
            e_n  = exp_sum;
        end
        sh_raw = 11'd1 - {e_n[EXP_W-1], e_n};
        sh     = (sh_raw > 11'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : sh_raw[4:0];
        ext    = {mg_n, 25'd0} >> sh;

        nrm_d         = '0;
        nrm_d.valid   = in_valid;
        nrm_d.m       = mg_n[MANT_W:1];
        nrm_d.g       = mg_n[0];
        nrm_d.s       = s_n;
        nrm_d.e       = e_n;
        nrm_d.sign    = sign_in;
        nrm_d.zero    = zero_in;
        nrm_d.invalid = invalid_in;
        // Denormalise: everything pushed past the guard folds into sticky.
        if (e_n <= 10'sd0) begin
            nrm_d.m  = ext[49:26];
            nrm_d.g  = ext[25];
            nrm_d.s  = s_n | (|ext[24:0]);
            nrm_d.e  = '0;
            nrm_d.uf = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nrm_q <= '0;
        end else if (!stall) begin
            nrm_q <= nrm_d;
        end
    end

    rne_rounder u_rnd (
        .m_i_dummy_unused_guard(1'b0),
        .m_i         (nrm_q.m),
        .g_i         (nrm_q.g),
        .s_i         (nrm_q.s),
        .e_i         (nrm_q.e),
        .uf_i        (nrm_q.uf),
        .zero_i      (nrm_q.zero),
        .invalid_i   (nrm_q.invalid),
        .m_o         (res_d.m),
        .e_o         (res_d.e),
        .overflow_o  (res_d.ovf),
        .underflow_o (res_d.uf),
        .inexact_o   (res_d.inexact)
    );

    assign res_d.valid   = nrm_q.valid;
    assign res_d.sign    = nrm_q.sign;
    assign res_d.zero    = nrm_q.zero;
    assign res_d.invalid = nrm_q.invalid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_q <= '0;
        end else if (!stall) begin
            res_q <= res_d;
        end
    end

    assign out_valid         = res_q.valid;
    assign Sz_out            = res_q.sign;
    assign M_out             = res_q.m;
    assign E_out             = res_q.e;
    assign initial_zero_flag = res_q.zero;
    assign overflow_flag     = res_q.ovf;
    assign underflow_case    = res_q.uf;
    assign invalid_flag      = res_q.invalid;
    assign inexact_flag      = res_q.inexact;

endmodule

// File: tb/tb_round_normalize.sv
// Scoreboard bench for round_normalize: directed vectors, random products,
// stall freeze and asynchronous reset.
module tb_round_normalize;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic        in_valid;
    logic [47:0] prod;
    logic [9:0]  exp_sum;
    logic        sign_in;
    logic        zero_in;
    logic        invalid_in;
    logic        out_valid;
    logic        Sz_out;
    logic [23:0] M_out;
    logic [7:0]  E_out;
    logic        initial_zero_flag;
    logic        overflow_flag;
    logic        underflow_case;
    logic        invalid_flag;
    logic        inexact_flag;

    always #5 CLK = ~CLK;

    round_normalize dut (
        .CLK               (CLK),
        .RST               (RST),
        .stall             (stall),
        .in_valid          (in_valid),
        .prod              (prod),
        .exp_sum           (exp_sum),
        .sign_in           (sign_in),
        .zero_in           (zero_in),
        .invalid_in        (invalid_in),
        .out_valid         (out_valid),
        .Sz_out            (Sz_out),
        .M_out             (M_out),
        .E_out             (E_out),
        .initial_zero_flag (initial_zero_flag),
        .overflow_flag     (overflow_flag),
        .underflow_case    (underflow_case),
        .invalid_flag      (invalid_flag),
        .inexact_flag      (inexact_flag)
    );

    typedef struct {
        logic [37:0] v;
        int          stamp;
    } sb_t;

    sb_t q[$];
    int  checks = 0;
    int  passed = 0;
    int  nedge  = 0;
    bit  adv    = 1'b0;

    function automatic logic [37:0] pk(
        logic sg, logic [23:0] m, logic [7:0] e,
        logic z, logic ov, logic uf, logic inv, logic inx);
        return {sg, m, e, z, ov, uf, inv, inx};
    endfunction

    function automatic logic [38:0] obs_now();
        return {out_valid, pk(Sz_out, M_out, E_out, initial_zero_flag,
                overflow_flag, underflow_case, invalid_flag, inexact_flag)};
    endfunction

    // Reference: bit-serial denormalise, then RNE on the kept 24 bits.
    function automatic logic [37:0] model(
        logic [47:0] p, logic [9:0] es, logic sg, logic z, logic inv);
        logic [24:0] k;
        logic [24:0] r;
        logic [23:0] m;
        logic        s, sub, ufc, ov, inx;
        logic [7:0]  eo;
        int          e, sh;
        if (p[47]) begin
            k = p[47:23]; s = |p[22:0]; e = int'($signed(es)) + 1;
        end else begin
            k = p[46:22]; s = |p[21:0]; e = int'($signed(es));
        end
        sub = (e <= 0);
        if (sub) begin
            sh = 1 - e;
            if (sh > 25) sh = 25;
            for (int i = 0; i < sh; i++) begin
                s = s | k[0];
                k = k >> 1;
            end
            e = 0;
        end
        m   = k[24:1];
        inx = k[0] | s;
        r   = {1'b0, m} + 25'(k[0] && (s || m[0]));
        ufc = 1'b0;
        ov  = 1'b0;
        if (r[24]) begin
            m = 24'h800000; e = e + 1;
        end else begin
            m = r[23:0];
        end
        if (sub) begin
            if (m[23]) e = 1;
            else ufc = 1'b1;
        end else if (e >= 255) begin
            ov = 1'b1; m = '0; e = 255;
        end
        eo = e[7:0];
        if (inv || z) begin
            m = '0; eo = '0; ov = 1'b0; ufc = 1'b0; inx = 1'b0;
        end
        return pk(sg, m, eo, z, ov, ufc, inv, inx);
    endfunction

    task automatic chk(string tag, logic [63:0] o, logic [63:0] x);
        checks++;
        assert (o === x) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, o, x);
    endtask

    always @(posedge CLK) begin
        adv <= !stall && !RST;
        if (!stall && !RST) nedge <= nedge + 1;
    end

    always @(negedge CLK) begin
        sb_t ent;
        if (!RST && adv && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_output", 64'(out_valid), 64'd0);
            end else begin
                ent = q.pop_front();
                chk("result", 64'(obs_now()), {25'd0, 1'b1, ent.v});
                chk("latency", 64'(nedge - ent.stamp), 64'd2);
            end
        end
    end

    // Called at posedge+2; the next edge accepts the operand.
    task automatic send(logic [47:0] p, logic [9:0] es, logic sg,
                        logic z, logic inv, logic [37:0] x);
        sb_t ent;
        prod = p; exp_sum = es; sign_in = sg;
        zero_in = z; invalid_in = inv; in_valid = 1'b1;
        ent.v = x;
        ent.stamp = nedge;
        q.push_back(ent);
        @(posedge CLK); #2;
        in_valid = 1'b0;
    endtask

    task automatic sendm(logic [47:0] p, logic [9:0] es, logic sg,
                         logic z, logic inv);
        send(p, es, sg, z, inv, model(p, es, sg, z, inv));
    endtask

    task automatic send_rand();
        logic [23:0] a, b;
        logic [9:0]  es;
        a  = {1'b1, 23'($urandom)};
        b  = {1'b1, 23'($urandom)};
        es = 10'($urandom_range(0, 360)) - 10'd60;
        sendm(48'(a) * 48'(b), es, 1'($urandom),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        logic [38:0] snap;
        RST = 1'b1; stall = 1'b0; in_valid = 1'b0; prod = '0;
        exp_sum = '0; sign_in = 1'b0; zero_in = 1'b0; invalid_in = 1'b0;
        #1;
        chk("reset_state", 64'(obs_now()), 64'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK); #2;

        send(48'h900000000000, 10'd127, 0, 0, 0,
             pk(0, 24'h900000, 8'd128, 0, 0, 0, 0, 0));
        send({1'b0, 24'hFFFFFF, 1'b1, 22'd0}, 10'd100, 0, 0, 0,
             pk(0, 24'h800000, 8'd101, 0, 0, 0, 0, 1));
        send({1'b0, 24'h800000, 1'b1, 22'd0}, 10'd50, 0, 0, 0,
             pk(0, 24'h800000, 8'd50, 0, 0, 0, 0, 1));
        send({1'b0, 24'h800001, 1'b1, 22'd0}, 10'd50, 0, 0, 0,
             pk(0, 24'h800002, 8'd50, 0, 0, 0, 0, 1));
        send(48'h800000000000, 10'd254, 1, 0, 0,
             pk(1, 24'h000000, 8'hFF, 0, 1, 0, 0, 0));
        send(48'h800000000000, 10'd253, 0, 0, 0,
             pk(0, 24'h800000, 8'hFE, 0, 0, 0, 0, 0));
        send(48'h400000000000, 10'h3FF, 0, 0, 0,
             pk(0, 24'h200000, 8'd0, 0, 0, 1, 0, 0));
        send(48'h400000000000, 10'd1, 0, 0, 0,
             pk(0, 24'h800000, 8'd1, 0, 0, 0, 0, 0));
        send({1'b0, 24'hFFFFFF, 23'd0}, 10'd0, 0, 0, 0,
             pk(0, 24'h800000, 8'd1, 0, 0, 0, 0, 1));
        send(48'h900000000000, 10'h39C, 0, 0, 0,
             pk(0, 24'h000000, 8'd0, 0, 0, 1, 0, 1));
        send(48'h900000000000, 10'd127, 1, 1, 0,
             pk(1, 24'h000000, 8'd0, 1, 0, 0, 0, 0));
        send(48'h900000000000, 10'd127, 0, 1, 1,
             pk(0, 24'h000000, 8'd0, 1, 0, 0, 1, 0));
        send(48'h800000000000, 10'd254, 0, 0, 1,
             pk(0, 24'h000000, 8'd0, 0, 0, 0, 1, 0));

        for (int i = 0; i < 40; i++) send_rand();

        for (int i = 0; i < 3; i++) send_rand();
        stall = 1'b1;
        in_valid = 1'b1;
        prod = 48'hC00000000001;
        exp_sum = 10'd7;
        snap = obs_now();
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #2;
            chk("stall_hold", 64'(obs_now()), 64'(snap));
        end
        stall = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_rand();

        for (int i = 0; i < 3; i++) send_rand();
        RST = 1'b1;
        #1;
        chk("reset_async", 64'(obs_now()), 64'd0);
        q.delete();
        @(posedge CLK); #2;
        RST = 1'b0;
        send(48'h900000000000, 10'd127, 0, 0, 0,
             pk(0, 24'h900000, 8'd128, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) send_rand();

        repeat (4) @(posedge CLK);
        #2;
        chk("drain_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
